// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-period helper and
// default clock/baud constants used by both uart_rx_stream and uart_tx.
package uart_pkg;

  localparam int DEF_CLK_FREQ = 27_000_000;
  localparam int DEF_BAUD     = 115_200;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_stream_if.sv
// Byte-stream valid/ready bundle between the receiver (master) and its
// consumer (slave).
interface uart_rx_stream_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; the head entry drives rdata_o
// directly. Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_rx_stream.sv
// Oversampling UART receiver feeding a small FIFO with a valid/ready output.
// Define UART_RX_PARITY_EN to require an even parity bit and add parity_err.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD       = DEF_BAUD,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  uart_rx_stream_if.master m,
  output logic frame_err,
  output logic overrun,
`ifdef UART_RX_PARITY_EN
  output logic parity_err,
`endif
  output logic busy
);

  localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic                 fall_edge;
  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 push;
  logic                 pop;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  // Synchronizer plus one extra flop so the start edge is seen on clean samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign fall_edge = rx_prev_q && !rx_s2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall_edge) state_d = START;
      end
      START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d     = '0;
          par_bad_d = ^{shift_q, rx_s2_q};
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d = '0;
          if (rx_s2_q) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) parity_err_d = 1'b1;
            else           push         = 1'b1;
`else
            push = 1'b1;
`endif
          end else begin
            // A low stop bit wins over a parity mismatch.
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s2_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign pop       = !fifo_empty && m.m_ready;
  assign overrun_d = overrun_q || (push && fifo_full && !pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Shift register is pure data; a partial byte is never pushed, so no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign m.m_data  = fifo_rdata;
  assign m.m_valid = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_stream.sv
// Scoreboard bench for uart_rx_stream: a serial driver queues expected bytes
// and error counts, a negedge monitor pops and compares on every handshake.
module tb_uart_rx_stream;

  localparam int CPB   = 16;
  localparam int HALF  = CPB / 2;
  localparam int DBITS = 8;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = DBITS + 2;
`else
  localparam int NBITS = DBITS + 1;
`endif
  // sync (2) + edge detect (1) + half bit + remaining bits up to the stop sample
  localparam int LAT = 2 + 1 + HALF + NBITS * CPB;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic rx      = 1'b1;
  logic frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
  logic par_flip = 1'b0;
  int   perr_seen = 0;
  int   perr_exp  = 0;
`endif

  int          errors    = 0;
  int          checks    = 0;
  logic [7:0]  exp_q[$];
  int          ferr_seen = 0;
  int          ferr_exp  = 0;
  int          busy_cyc  = 0;
  int          cyc       = 0;
  int          start_cyc = 0;
  logic        lat_armed = 1'b0;
  logic        rnd_ready = 1'b0;
  logic        ready_req = 1'b0;
  logic        hold_prev = 1'b0;
  logic [7:0]  data_prev = '0;

  always #5 clk = ~clk;

  uart_rx_stream_if #(.DATA_BITS(DBITS)) ifc ();

  uart_rx_stream #(
    .CLK_FREQ   (16),
    .BAUD       (1),
    .DATA_BITS  (DBITS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .m          (ifc.master),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    @(negedge clk);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < DBITS; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop_bit);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // m_ready changes just after the rising edge so the monitor sees a settled value.
  initial begin
    ifc.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ifc.m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_req;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", {31'd0, ifc.m_valid}, 32'd1);
        chk("hold_data", {24'd0, ifc.m_data}, {24'd0, data_prev});
      end
      if (lat_armed && ifc.m_valid) begin
        chk("latency", cyc - start_cyc, LAT);
        lat_armed = 1'b0;
      end
      if (ifc.m_valid && ifc.m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", ifc.m_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (ifc.m_data !== e) begin
            errors++;
            $display("FAIL byte: got %0h expected %0h", ifc.m_data, e);
          end
        end
      end
      if (frame_err === 1'b1) ferr_seen++;
      if (busy === 1'b1) busy_cyc++;
`ifdef UART_RX_PARITY_EN
      if (parity_err === 1'b1) perr_seen++;
`endif
      hold_prev = ifc.m_valid && !ifc.m_ready;
      data_prev = ifc.m_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       bad;

    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, ifc.m_valid}, 32'd0);
    chk("rst_data", {24'd0, ifc.m_data}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // single byte with consumer ready
    ready_req = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back(8'hA5);
    lat_armed = 1'b1;
    send_frame(8'hA5, 1'b1);
    repeat (10) @(negedge clk);
    chk("s1_drain", exp_q.size(), 0);
    chk("s1_lat_seen", {31'd0, lat_armed}, 32'd0);
    chk("s1_ferr", ferr_seen, ferr_exp);
    chk("s1_ovr", {31'd0, overrun}, 32'd0);

    // short glitch shorter than half a bit
    busy_cyc = 0;
    @(negedge clk);
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_busy_cycles", busy_cyc, HALF);
    chk("glitch_busy_end", {31'd0, busy}, 32'd0);
    chk("glitch_ferr", ferr_seen, ferr_exp);

    // framing error followed by a held-low line
    send_frame(8'h3C, 1'b0);
    ferr_exp++;
    repeat (40) @(negedge clk);
    chk("brk_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("brk_ferr", ferr_seen, ferr_exp);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    repeat (10) @(negedge clk);
    chk("brk_next_drain", exp_q.size(), 0);

    // fill past capacity with the consumer stalled
    ready_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_ovr", {31'd0, overrun}, 32'd0);
    for (int b = 1; b <= 5; b++) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1);
    end
    repeat (5) @(negedge clk);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    chk("ovr_valid", {31'd0, ifc.m_valid}, 32'd1);
    chk("ovr_head", {24'd0, ifc.m_data}, 32'd1);
    ready_req = 1'b1;
    repeat (12) @(negedge clk);
    chk("ovr_drain", exp_q.size(), 0);
    chk("ovr_empty", {31'd0, ifc.m_valid}, 32'd0);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);

    // reset in the middle of a frame, with a byte still buffered
    ready_req = 1'b0;
    repeat (3) @(negedge clk);
    send_frame(8'h33, 1'b1);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_valid", {31'd0, ifc.m_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, ifc.m_data}, 32'd0);
    chk("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("mid_rst_ovr", {31'd0, overrun}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    reset_n   = 1'b1;
    ready_req = 1'b1;
    repeat (5) @(negedge clk);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    repeat (10) @(negedge clk);
    chk("post_rst_drain", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1);
    par_flip = 1'b1;
    perr_exp++;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    repeat (10) @(negedge clk);
    chk("par_err", perr_seen, perr_exp);
    chk("par_drain", exp_q.size(), 0);
`endif

    // random bytes, random consumer stalls, occasional bad stop bits
    rnd_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      d   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 5) == 0);
      if (!bad) exp_q.push_back(d);
      send_frame(d, !bad);
      if (bad) begin
        ferr_exp++;
        repeat ($urandom_range(0, 30)) @(negedge clk);
        rx = 1'b1;
      end
      repeat ($urandom_range(4, 20)) @(negedge clk);
    end
    rnd_ready = 1'b0;
    ready_req = 1'b1;
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    chk("rand_drain", exp_q.size(), 0);
    chk("rand_ferr", ferr_seen, ferr_exp);
    chk("rand_ovr", {31'd0, overrun}, 32'd0);
`ifdef UART_RX_PARITY_EN
    chk("rand_perr", perr_seen, perr_exp);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_stream.md
Name: uart_rx_stream

Overview:
- Oversampling UART receiver: serial line in, byte stream out through a valid/ready handshake, buffered by a small FIFO.
- Receive-side counterpart of the existing uart_tx, with flow control, error reporting and buffering.
- Sits between the board uart_rx pin and any byte consumer, such as a command decoder or a loopback to uart_tx.

Parameters:
- CLK_FREQ, 27000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- DATA_BITS, 8, data bits per frame (5..8), sent LSB first.
- FIFO_DEPTH, 4, output buffer depth in entries (power of 2, ≥2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- m_data  output  DATA_BITS  byte at the FIFO head.
- m_valid  output  1  FIFO not empty.
- m_ready  input  1  consumer accepts; a pop occurs when m_valid && m_ready.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- overrun  output  1  sticky; set when a good byte arrives while the FIFO is full and no pop occurs that cycle.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync-safe deassert via the 2-FF path): FSM=IDLE, FIFO empty, m_valid=0, m_data=0, frame_err=0, overrun=0, busy=0. The synchronizer flops reset to 1.
- rx passes through a 2-FF synchronizer (reset value 1). All sampling uses the synchronized signal.
- CLKS_PER_BIT = CLK_FREQ/BAUD (integer truncation); HALF = CLKS_PER_BIT/2. Counter width is $clog2(CLKS_PER_BIT).
- FSM transitions:
  - IDLE: on a synchronized 1→0 transition, clear the counter and go to START.
  - START: count to HALF-1, then sample. If the sample is 0, go to DATA. If it is 1 (glitch), return to IDLE with no output.
  - DATA: every CLKS_PER_BIT cycles, sample into a shift register, LSB first. After DATA_BITS samples, go to STOP (or PARITY when the feature is enabled).
  - STOP: after CLKS_PER_BIT cycles, sample the line.
    - Sample 1: push the byte, go to IDLE.
    - Sample 0: pulse frame_err for 1 cycle, discard the byte, go to BREAK.
  - BREAK: wait for the synchronized line to read 1, then go to IDLE. A held-low line never generates repeated frames.
- Latency: the pushed byte appears on m_data with m_valid=1 on the cycle after the stop-bit sample. The path from rx pin to stop sample adds 2 cycles of synchronizer delay.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.
  - m_data is driven from the head entry (registered storage, no bypass).
  - m_data and m_valid stay stable while m_valid && !m_ready.
- Boundary conditions:
  - Push while full with a same-cycle pop: the push is accepted and overrun does not set.
  - Push while full with no pop: the byte is dropped and overrun sets. overrun clears only on reset.
  - Push while empty with a same-cycle m_ready: there is no pop that cycle, because m_valid was 0.
  - Wrap-around: pointers roll over modulo 2·FIFO_DEPTH.
- Reset mid-frame discards the partial byte and all FIFO contents immediately.
- The next start edge is detected on the first cycle back in IDLE. Back-to-back frames with a 1-bit stop are supported.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted after DATA.
  - The parity bit is sampled one CLKS_PER_BIT after the last data bit; even parity is required.
  - On mismatch, the byte is discarded and a new output, parity_err, pulses for 1 cycle at the stop-bit sample.
  - A stop-bit error takes precedence: frame_err pulses and parity_err does not.
- Not defined: no PARITY state, no parity_err port, and the frame is start + DATA_BITS + stop.

Decomposition:
- Package uart_pkg holds:
  - the state enum: IDLE, START, DATA, PARITY, STOP, BREAK;
  - the function computing CLKS_PER_BIT from CLK_FREQ and BAUD, shared with uart_tx;
  - the default constants for CLK_FREQ and BAUD.
- Sub-module: sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty). The FSM and synchronizer stay in uart_rx_stream.

Test Plan:
- All scenarios run with CLK_FREQ=16, BAUD=1, so CLKS_PER_BIT=16.
- Send 0xA5, m_ready=1 → m_valid high for exactly 1 cycle with m_data=0xA5, on the cycle after the stop sample. frame_err and overrun stay 0.
- Drive rx low for 6 cycles (< HALF) from idle → FSM returns to IDLE with no m_valid and no frame_err; busy high only during the glitch window.
- Send 0x3C with the stop bit driven 0, then hold rx low for 40 cycles, then release → one frame_err pulse, no m_valid, no further pulses while held low. A following 0x81 is received correctly.
- With m_ready=0, send 0x01..0x05 → after the 5th frame, overrun=1 and m_valid=1. Raising m_ready pops 0x01, 0x02, 0x03, 0x04 in order, then m_valid=0.
- Assert reset_n=0 mid-way through the DATA bits of 0xFF, release, then send 0x5A → only 0x5A is output, and all outputs read their reset values during reset.
- UART_RX_PARITY_EN: send 0x07 with parity 1 (correct) → byte output. Send 0x07 with parity 0 → parity_err pulse and no m_valid.
